mem_access_unit: RTL and testbench

- Data-memory access stage between the EXE_MEM pipeline register and a multi-cycle data-memory bus.
- Replaces the single-cycle dataMem path.
- Converts load/store requests into a req/ack bus transaction with byte enables, and extracts and sign- or zero-extends read data toward MEM_WB.
- Stalls the pipeline while a transaction is outstanding and flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: access sizes and FSM states.
package mem_access_unit_pkg;

    localparam int          MEM_SIZE_LENGTH = 2;
    localparam logic [1:0]  MEM_SIZE_BYTE   = 2'b00;
    localparam logic [1:0]  MEM_SIZE_HALF   = 2'b01;
    localparam logic [1:0]  MEM_SIZE_WORD   = 2'b10;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'b00,
        MAU_REQ  = 2'b01,
        MAU_DONE = 2'b10
    } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables / replicated store data on the
// request side, lane extraction and sign/zero extension on the read side.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    input  logic [31:0] rd_word,
    input  logic [1:0]  rd_addr_lo,
    input  logic [1:0]  rd_size,
    input  logic        rd_sext,
    output logic [31:0] rd_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Request side: lanes follow little-endian byte order; size 2'b11 acts as WORD
    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (size)
            MEM_SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_SIZE_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

    // Read side: pick the addressed lane and fill the upper bits
    always_comb begin
        rd_byte = rd_word[7:0];
        case (rd_addr_lo)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = rd_addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        case (rd_size)
            MEM_SIZE_BYTE: rd_data = {{24{rd_sext & rd_byte[7]}}, rd_byte};
            MEM_SIZE_HALF: rd_data = {{16{rd_sext & rd_half[15]}}, rd_half};
            default:       rd_data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns EXE_MEM load/store requests into a
// registered req/ack bus transaction, stalls the pipeline meanwhile and
// returns extended load data toward MEM_WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit TIMEOUT_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_sext,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mau_state_e  state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic        bus_req_reg, bus_we_reg, bus_err_reg;
    logic [31:0] bus_addr_reg, bus_wdata_reg, rdata_reg;
    logic [3:0]  bus_be_reg;
    logic [1:0]  lat_addr_lo_reg, lat_size_reg;
    logic        lat_sext_reg;

    logic        access, misaligned, timeout_hit;
    logic [3:0]  req_be;
    logic [31:0] req_wdata, rd_ext;

    assign access      = mem_re | mem_we;
    assign timeout_hit = TIMEOUT_EN && (cnt_reg == TMO_LAST);

    mem_lane_align u_lane (
        .addr_lo    (mem_addr[1:0]),
        .size       (mem_size),
        .wdata      (mem_wdata),
        .be         (req_be),
        .wdata_rep  (req_wdata),
        .misaligned (misaligned),
        .rd_word    (bus_rdata),
        .rd_addr_lo (lat_addr_lo_reg),
        .rd_size    (lat_size_reg),
        .rd_sext    (lat_sext_reg),
        .rd_data    (rd_ext)
    );

    // State, counter, bus and result registers; reset kills any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= MAU_IDLE;
            cnt_reg         <= 8'd0;
            bus_req_reg     <= 1'b0;
            bus_we_reg      <= 1'b0;
            bus_addr_reg    <= 32'd0;
            bus_be_reg      <= 4'd0;
            bus_wdata_reg   <= 32'd0;
            bus_err_reg     <= 1'b0;
            rdata_reg       <= 32'd0;
            lat_addr_lo_reg <= 2'd0;
            lat_size_reg    <= 2'd0;
            lat_sext_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bus_err_reg <= 1'b0;
            case (state_reg)
                MAU_IDLE: begin
                    if (access && !misaligned) begin
                        bus_req_reg     <= 1'b1;
                        bus_we_reg      <= mem_we;
                        bus_addr_reg    <= {mem_addr[31:2], 2'b00};
                        bus_be_reg      <= req_be;
                        bus_wdata_reg   <= req_wdata;
                        cnt_reg         <= 8'd0;
                        lat_addr_lo_reg <= mem_addr[1:0];
                        lat_size_reg    <= mem_size;
                        lat_sext_reg    <= mem_sext;
                    end
                end
                MAU_REQ: begin
                    if (bus_ack) begin
                        bus_req_reg <= 1'b0;
                        if (!bus_we_reg) begin
                            rdata_reg <= rd_ext;
                        end
                    end else if (timeout_hit) begin
                        bus_req_reg <= 1'b0;
                        bus_err_reg <= 1'b1;
                        if (!bus_we_reg) begin
                            rdata_reg <= 32'd0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state plus combinational stall / misalignment flag; both forced low in reset
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        addr_err   = 1'b0;
        case (state_reg)
            MAU_IDLE: begin
                if (access && !misaligned) begin
                    stall      = rst;
                    state_next = MAU_REQ;
                end else if (access) begin
                    addr_err = rst;
                end
            end
            MAU_REQ: begin
                stall = rst;
                if (bus_ack || timeout_hit) begin
                    state_next = MAU_DONE;
                end
            end
            default: begin
                state_next = MAU_IDLE;
            end
        endcase
    end

    assign rdata     = rdata_reg;
    assign bus_err   = bus_err_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_be    = bus_be_reg;
    assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single accesses plus
// hand-written sequences for timeout, back-to-back and reset cases.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re, mem_we, mem_sext;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] rdata;
    logic        stall, addr_err, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;
    int rises;
    logic prev_req;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] brd;
        int          ack_n;
        logic        mis;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_sext  (mem_sext),
        .rdata     (rdata),
        .stall     (stall),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic re, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [1:0] size, input logic sext,
                                input logic [31:0] brd, input int ack_n, input logic mis,
                                input logic [3:0] be, input logic ewe, input logic [31:0] ewd,
                                input logic [31:0] erd);
        vec_t v;
        v.re = re; v.we = we; v.addr = addr; v.wdata = wd; v.size = size; v.sext = sext;
        v.brd = brd; v.ack_n = ack_n; v.mis = mis; v.exp_be = be; v.exp_we = ewe;
        v.exp_wd = ewd; v.exp_rd = erd;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        if (bus_req && !prev_req) rises++;
        prev_req = bus_req;
    endtask

    task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] size, input logic sext);
        mem_re = re; mem_we = we; mem_addr = addr; mem_wdata = wd;
        mem_size = size; mem_sext = sext;
    endtask

    // One complete access; entered and left at edge+1 with the FSM idle
    task automatic do_access(input vec_t v, input int idx);
        int stalls;
        stalls = 0;
        drive(v.re, v.we, v.addr, v.wdata, v.size, v.sext);
        #1;
        if (v.mis) begin
            chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
            chk("mis_stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            chk("mis_no_req", {31'd0, bus_req}, 32'd0);
            chk("mis_rdata", rdata, v.exp_rd);
        end else begin
            chk("addr_err_low", {31'd0, addr_err}, 32'd0);
            if (stall) stalls++;
            @(posedge clk); #1;
            chk("req_high", {31'd0, bus_req}, 32'd1);
            chk("bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
            chk("bus_be", {28'd0, bus_be}, {28'd0, v.exp_be});
            chk("bus_we", {31'd0, bus_we}, {31'd0, v.exp_we});
            if (v.exp_we) chk("bus_wdata", bus_wdata, v.exp_wd);
            for (int n = 1; n <= v.ack_n; n++) begin
                if (stall) stalls++;
                if (n == v.ack_n) begin
                    bus_ack = 1'b1;
                    bus_rdata = v.brd;
                end
                @(posedge clk); #1;
                bus_ack = 1'b0;
                bus_rdata = 32'd0;
            end
            chk("done_req_low", {31'd0, bus_req}, 32'd0);
            chk("done_stall", {31'd0, stall}, 32'd0);
            chk("done_bus_err", {31'd0, bus_err}, 32'd0);
            chk("rdata", rdata, v.exp_rd);
            chk("stall_cycles", stalls, 32'(1 + v.ack_n));
            @(posedge clk); #1;
            chk("no_retrigger", {31'd0, bus_req}, 32'd0);
        end
        $display("txn %0d: re=%0b we=%0b addr=%h size=%0d be=%h rdata=%h", idx, v.re, v.we,
                 v.addr, v.size, bus_be, rdata);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    endtask

    initial begin
        int n;
        vec_t v;
        vecs[0]  = mk(0, 1, 32'h100, 32'hDEADBEEF, MEM_SIZE_WORD, 0, 32'h0, 3, 0, 4'hF, 1, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mk(1, 0, 32'h103, 32'h0, MEM_SIZE_BYTE, 1, 32'h80FF_0000, 1, 0, 4'h8, 0, 32'h0, 32'hFFFF_FF80);
        vecs[2]  = mk(1, 0, 32'h103, 32'h0, MEM_SIZE_BYTE, 0, 32'h80FF_0000, 1, 0, 4'h8, 0, 32'h0, 32'h0000_0080);
        vecs[3]  = mk(0, 1, 32'h22, 32'h0000_ABCD, MEM_SIZE_HALF, 0, 32'h0, 2, 0, 4'hC, 1, 32'hABCD_ABCD, 32'h0000_0080);
        vecs[4]  = mk(1, 0, 32'h201, 32'h0, MEM_SIZE_HALF, 1, 32'h0, 0, 1, 4'h0, 0, 32'h0, 32'h0000_0080);
        vecs[5]  = mk(1, 0, 32'h202, 32'h0, MEM_SIZE_HALF, 1, 32'h8001_1234, 1, 0, 4'hC, 0, 32'h0, 32'hFFFF_8001);
        vecs[6]  = mk(1, 0, 32'h200, 32'h0, MEM_SIZE_HALF, 0, 32'h8001_F234, 1, 0, 4'h3, 0, 32'h0, 32'h0000_F234);
        vecs[7]  = mk(1, 0, 32'h204, 32'h0, 2'b11, 1, 32'h1234_5678, 2, 0, 4'hF, 0, 32'h0, 32'h1234_5678);
        vecs[8]  = mk(0, 1, 32'h101, 32'h0000_00A5, MEM_SIZE_BYTE, 0, 32'h0, 1, 0, 4'h2, 1, 32'hA5A5_A5A5, 32'h1234_5678);
        vecs[9]  = mk(0, 1, 32'h102, 32'h1111_2222, MEM_SIZE_WORD, 0, 32'h0, 0, 1, 4'h0, 0, 32'h0, 32'h1234_5678);
        vecs[10] = mk(1, 0, 32'h102, 32'h0, MEM_SIZE_BYTE, 1, 32'h007F_0000, 1, 0, 4'h4, 0, 32'h0, 32'h0000_007F);
        vecs[11] = mk(1, 1, 32'h300, 32'h1122_3344, MEM_SIZE_WORD, 0, 32'h0, 1, 0, 4'hF, 1, 32'h1122_3344, 32'h0000_007F);

        rst = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        prev_req = 1'b0;
        rises = 0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i], i);
        end

        // Load timeout: bus_req for exactly TIMEOUT_CYCLES, bus_err in DONE, rdata cleared
        drive(1'b1, 1'b0, 32'h40, 32'd0, MEM_SIZE_WORD, 1'b0);
        @(posedge clk); #1;
        n = 0;
        while (bus_req && n < 10) begin
            n++;
            @(posedge clk); #1;
        end
        chk("tmo_req_cycles", n, 32'd4);
        chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
        chk("tmo_rdata", rdata, 32'd0);
        chk("tmo_stall", {31'd0, stall}, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        @(posedge clk); #1;
        chk("tmo_err_pulse", {31'd0, bus_err}, 32'd0);
        $display("txn tmo: load 0x40 req_cycles=%0d rdata=%h", n, rdata);

        // Ack on the expiry cycle wins over the timeout
        v = mk(1, 0, 32'h400, 32'h0, MEM_SIZE_WORD, 0, 32'hCAFE_F00D, 4, 0, 4'hF, 0, 32'h0, 32'hCAFE_F00D);
        do_access(v, 100);

        // Stray ack while idle is ignored
        bus_ack = 1'b1;
        bus_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        chk("stray_ack_rdata", rdata, 32'hCAFE_F00D);
        chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
        $display("txn stray ack: rdata=%h", rdata);

        // Request held through DONE: one transaction per request, no overlap
        rises = 0;
        prev_req = bus_req;
        drive(1'b1, 1'b0, 32'h500, 32'd0, MEM_SIZE_WORD, 1'b0);
        #1;
        chk("b2b_stall0", {31'd0, stall}, 32'd1);
        tick;
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        tick;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        chk("b2b_rdata1", rdata, 32'h0BAD_F00D);
        chk("b2b_done_stall", {31'd0, stall}, 32'd0);
        tick;
        chk("b2b_idle_req", {31'd0, bus_req}, 32'd0);
        chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
        tick;
        bus_ack = 1'b1; bus_rdata = 32'h600D_CAFE;
        tick;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        tick;
        tick;
        chk("b2b_rises", rises, 32'd2);
        chk("b2b_rdata2", rdata, 32'h600D_CAFE);
        $display("txn b2b: transactions=%0d rdata=%h", rises, rdata);

        // Asynchronous reset in the second REQ cycle of a pending load
        drive(1'b1, 1'b0, 32'h10, 32'd0, MEM_SIZE_BYTE, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_req_high", {31'd0, bus_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req", {31'd0, bus_req}, 32'd0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        $display("txn reset: bus_req=%0b rdata=%h", bus_req, rdata);
        v = mk(1, 0, 32'h12, 32'h0, MEM_SIZE_BYTE, 0, 32'h00C3_0000, 1, 0, 4'h4, 0, 32'h0, 32'h0000_00C3);
        do_access(v, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
